// File: rtl/rx_frame_buffer.sv
// Receive payload buffer: absorbs a non-stallable beat stream into a FWFT FIFO,
// presents it on an AXI-Stream master, raises a hysteretic pause and flags drops.
module rx_frame_buffer #(
    parameter int PAYLOAD_WIDTH = 240,
    parameter int DEPTH         = 64,
    parameter int PAUSE_ON      = 48,
    parameter int PAUSE_OFF     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAYLOAD_WIDTH-1:0]   s_axis_tdata,
    input  logic [PAYLOAD_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic [PAYLOAD_WIDTH-1:0]   m_axis_tdata,
    output logic [PAYLOAD_WIDTH/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       pause_req,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int KW        = PAYLOAD_WIDTH / 8;
    localparam int AW        = $clog2(DEPTH);
    localparam int OW        = AW + 1;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int BW        = PAYLOAD_WIDTH + KW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PAUSE = 1'b1
    } pause_state_t;

    logic [BW-1:0] ram_r [RAM_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] occ_r;
    logic [BW-1:0] out_beat_r;
    logic          out_valid_r;
    logic          overflow_r;
    logic          pause_req_r;
    pause_state_t  pause_state_r;
    pause_state_t  pause_next_s;

    logic [BW-1:0] in_beat_s;
    logic [OW-1:0] ram_cnt_s;
    logic [OW-1:0] occ_next_s;
    logic          pop_s;
    logic          full_s;
    logic          accept_s;
    logic          reject_s;
    logic          ram_empty_s;
    logic          load_out_s;
    logic          ram_rd_s;
    logic          bypass_s;
    logic          ram_wr_s;

    // Circular pointer advance over the DEPTH-1 RAM slots.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == AW'(RAM_DEPTH - 1)) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    assign in_beat_s     = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign m_axis_tdata  = out_beat_r[BW-1 -: PAYLOAD_WIDTH];
    assign m_axis_tkeep  = out_beat_r[KW:1];
    assign m_axis_tlast  = out_beat_r[0];
    assign m_axis_tvalid = out_valid_r;
    assign occupancy     = occ_r;
    assign pause_req     = pause_req_r;
    assign overflow      = overflow_r;

    // Accept/reject decision and steering between RAM, bypass and output register.
    always_comb begin
        pop_s       = out_valid_r && m_axis_tready;
        full_s      = (occ_r == OW'(DEPTH));
        accept_s    = s_axis_tvalid && (!full_s || pop_s);
        reject_s    = s_axis_tvalid && full_s && !pop_s;
        // The output register only empties when the RAM is empty, so this never underflows.
        ram_cnt_s   = occ_r - OW'(out_valid_r);
        ram_empty_s = (ram_cnt_s == {OW{1'b0}});
        load_out_s  = !out_valid_r || pop_s;
        ram_rd_s    = load_out_s && !ram_empty_s;
        bypass_s    = load_out_s && ram_empty_s && accept_s;
        ram_wr_s    = accept_s && !bypass_s;
        occ_next_s  = occ_r + OW'(accept_s) - OW'(pop_s);
    end

    // Payload storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            ram_r[wr_ptr_r] <= in_beat_s;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (ram_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (ram_rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            occ_r <= occ_next_s;
        end
    end

    // Output register: RAM head first, then bypass of the incoming beat, else empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat_r  <= {BW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (ram_rd_s) begin
            out_beat_r  <= ram_r[rd_ptr_r];
            out_valid_r <= 1'b1;
        end else if (bypass_s) begin
            out_beat_r  <= in_beat_s;
            out_valid_r <= 1'b1;
        end else if (load_out_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Pause hysteresis next-state, evaluated on the post-update occupancy.
    always_comb begin
        pause_next_s = pause_state_r;
        case (pause_state_r)
            ST_IDLE: begin
                if (occ_next_s >= OW'(PAUSE_ON)) begin
                    pause_next_s = ST_PAUSE;
                end else begin
                    pause_next_s = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (occ_next_s <= OW'(PAUSE_OFF)) begin
                    pause_next_s = ST_IDLE;
                end else begin
                    pause_next_s = ST_PAUSE;
                end
            end
            default: begin
                pause_next_s = ST_IDLE;
            end
        endcase
    end

    // Pause state register and its registered request output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_state_r <= ST_IDLE;
            pause_req_r   <= 1'b0;
        end else begin
            pause_state_r <= pause_next_s;
            pause_req_r   <= (pause_next_s == ST_PAUSE);
        end
    end

    // Sticky drop flag; a rejection in the same cycle beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (reject_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Self-checking bench for rx_frame_buffer: directed vector table plus
// scoreboard of accepted beats compared against the master output.
module tb_rx_frame_buffer;

    localparam int PW        = 240;
    localparam int KW        = PW / 8;
    localparam int DEPTH     = 64;
    localparam int PAUSE_ON  = 48;
    localparam int PAUSE_OFF = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic [PW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [6:0]    occupancy;
    logic          pause_req;
    logic          overflow;
    logic          overflow_clr;

    typedef struct packed {
        logic [PW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic s_valid;
        logic s_last;
        logic ready;
        int   exp_occ;
        logic exp_tvalid;
    } vec_t;

    beat_t sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    seq    = 0;
    int    mdl_occ = 0;
    logic  mdl_pause = 1'b0;
    logic  mdl_ovf   = 1'b0;
    vec_t  vecs[10];

    rx_frame_buffer #(
        .PAYLOAD_WIDTH(PW),
        .DEPTH(DEPTH),
        .PAUSE_ON(PAUSE_ON),
        .PAUSE_OFF(PAUSE_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .occupancy(occupancy),
        .pause_req(pause_req),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_beat(input logic last);
        seq++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {8{30'(seq)}};
        s_axis_tkeep  = 30'(seq * 5 + 3);
        s_axis_tlast  = last;
    endtask

    // Check head against the scoreboard, predict the edge, advance, check state.
    task automatic tick();
        logic  pop_m;
        logic  acc;
        logic  rej;
        int    nxt;
        beat_t hd;
        chk("m_tvalid", PW'(m_axis_tvalid), PW'(mdl_occ > 0));
        pop_m = (mdl_occ > 0) && m_axis_tready;
        if (mdl_occ > 0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_empty: got head %0h expected no beat", m_axis_tdata);
            end else begin
                hd = sb[0];
                chk("m_tdata", m_axis_tdata, hd.d);
                chk("m_tkeep", PW'(m_axis_tkeep), PW'(hd.k));
                chk("m_tlast", PW'(m_axis_tlast), PW'(hd.l));
                if (pop_m) begin
                    void'(sb.pop_front());
                end
            end
        end
        acc = s_axis_tvalid && ((mdl_occ < DEPTH) || pop_m);
        rej = s_axis_tvalid && !acc;
        if (acc) begin
            sb.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast});
        end
        nxt = mdl_occ + int'(acc) - int'(pop_m);
        if (!mdl_pause && nxt >= PAUSE_ON) begin
            mdl_pause = 1'b1;
        end else if (mdl_pause && nxt <= PAUSE_OFF) begin
            mdl_pause = 1'b0;
        end
        if (rej) begin
            mdl_ovf = 1'b1;
        end else if (overflow_clr) begin
            mdl_ovf = 1'b0;
        end
        mdl_occ = nxt;
        @(posedge clk);
        #1;
        chk("occupancy", PW'(occupancy), PW'(mdl_occ));
        chk("pause_req", PW'(pause_req), PW'(mdl_pause));
        chk("overflow", PW'(overflow), PW'(mdl_ovf));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tvalid"}, PW'(m_axis_tvalid), '0);
        chk({tag, "_tdata"}, m_axis_tdata, '0);
        chk({tag, "_tkeep"}, PW'(m_axis_tkeep), '0);
        chk({tag, "_tlast"}, PW'(m_axis_tlast), '0);
        chk({tag, "_occ"}, PW'(occupancy), '0);
        chk({tag, "_pause"}, PW'(pause_req), '0);
        chk({tag, "_ovf"}, PW'(overflow), '0);
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        overflow_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // Five beats held, then released back-to-back.
        for (int i = 0; i < 5; i++) begin
            vecs[i] = '{1'b1, (i == 4), 1'b0, i + 1, 1'b1};
        end
        for (int i = 0; i < 5; i++) begin
            vecs[5 + i] = '{1'b0, 1'b0, 1'b1, 4 - i, (i != 4)};
        end
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].s_valid) begin
                set_beat(vecs[i].s_last);
            end else begin
                s_axis_tvalid = 1'b0;
            end
            m_axis_tready = vecs[i].ready;
            tick();
            chk("tbl_occ", PW'(occupancy), PW'(vecs[i].exp_occ));
            chk("tbl_tvalid", PW'(m_axis_tvalid), PW'(vecs[i].exp_tvalid));
        end
        s_axis_tvalid = 1'b0;

        // Single-beat latency through the bypass path.
        m_axis_tready = 1'b0;
        set_beat(1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("lat_tvalid", PW'(m_axis_tvalid), PW'(1));
        chk("lat_tdata", m_axis_tdata, {8{30'(seq)}});
        m_axis_tready = 1'b1;
        tick();

        // Fill to full, drop one beat, clear the flag.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(1'b0);
            tick();
        end
        set_beat(1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("ovf_set", PW'(overflow), PW'(1));
        chk("ovf_occ", PW'(occupancy), PW'(DEPTH));
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", PW'(overflow), PW'(0));

        // Full-rate in and out while full.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_beat(i == 19);
            tick();
            chk("full_thru_occ", PW'(occupancy), PW'(DEPTH));
        end
        s_axis_tvalid = 1'b0;
        repeat (DEPTH) tick();
        chk("drained_occ", PW'(occupancy), PW'(0));

        // Pause hysteresis.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 47; i++) begin
            set_beat(1'b0);
            tick();
        end
        chk("hyst_47", PW'(pause_req), PW'(0));
        set_beat(1'b0);
        tick();
        s_axis_tvalid = 1'b0;
        chk("hyst_48", PW'(pause_req), PW'(1));
        m_axis_tready = 1'b1;
        repeat (31) tick();
        chk("hyst_17_occ", PW'(occupancy), PW'(17));
        chk("hyst_17", PW'(pause_req), PW'(1));
        tick();
        chk("hyst_16", PW'(pause_req), PW'(0));

        // Climb back into pause, settle at 30, then reset asynchronously.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_beat(1'b0);
            tick();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (18) tick();
        m_axis_tready = 1'b0;
        chk("pre_rst_occ", PW'(occupancy), PW'(30));
        chk("pre_rst_pause", PW'(pause_req), PW'(1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sb.delete();
        mdl_occ   = 0;
        mdl_pause = 1'b0;
        mdl_ovf   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_beat(1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("post_rst_tvalid", PW'(m_axis_tvalid), PW'(1));
        chk("post_rst_occ", PW'(occupancy), PW'(1));
        m_axis_tready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Receive-side payload buffer directly downstream of the RX width converter. Accepts the converter's non-backpressurable payload beats (valid-only stream), stores them in a DEPTH-entry FIFO and presents them on an AXI-Stream master with tready. Generates a hysteretic pause request that the flow-control logic returns to the far-end transmitter before the buffer can overflow. Flags any beat lost to a full buffer.

## Interface
- PAYLOAD_WIDTH, 240: payload bits per beat; multiple of 8.
- DEPTH, 64: entries, power of two, ≥ 4; includes the output register.
- PAUSE_ON, 48: occupancy at or above which pause_req asserts.
- PAUSE_OFF, 16: occupancy at or below which pause_req deasserts; PAUSE_OFF < PAUSE_ON ≤ DEPTH.

- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  PAYLOAD_WIDTH  beat from the width converter.
- s_axis_tkeep  in  PAYLOAD_WIDTH/8  byte enables, stored verbatim.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  beat present; no ready, the source cannot stall.
- m_axis_tdata  out  PAYLOAD_WIDTH  head beat.
- m_axis_tkeep  out  PAYLOAD_WIDTH/8  head byte enables.
- m_axis_tlast  out  1  head end-of-packet.
- m_axis_tvalid  out  1  head beat valid.
- m_axis_tready  in  1  consumer accepts the head beat.
- occupancy  out  $clog2(DEPTH)+1  beats held, including the output register.
- pause_req  out  1  registered pause request.
- overflow  out  1  sticky: a beat was dropped.
- overflow_clr  in  1  synchronous clear of overflow.

## Operation
- Storage: circular RAM of DEPTH-1 entries plus one output register (first-word-fall-through). Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH-1.
- pop = m_axis_tvalid && m_axis_tready.
- Write accepted when s_axis_tvalid && (occupancy < DEPTH || pop). A simultaneous pop frees space in the same cycle, so a full buffer being drained loses nothing.
- Write rejected when s_axis_tvalid && occupancy == DEPTH && !pop. The beat is discarded and overflow is set the next cycle. No other state changes.
- occupancy_next = occupancy + accepted − pop. It never exceeds DEPTH and never underflows.
- Output register load priority:
  - If the register is empty or being popped, load the RAM head when the RAM is non-empty.
  - Otherwise load the incoming beat directly (bypass) when the RAM is empty.
  - Otherwise the register empties.
- Ordering is strictly preserved. tdata, tkeep and tlast travel together unmodified.
- m_axis_* are stable while tvalid && !tready.
- pause_req is a two-state FSM evaluated on occupancy_next:
  - IDLE → PAUSE when occupancy_next ≥ PAUSE_ON.
  - PAUSE → IDLE when occupancy_next ≤ PAUSE_OFF.
  - Otherwise the state holds. pause_req is high in PAUSE.
- overflow: set on any rejected beat. Cleared by overflow_clr when no rejection occurs in the same cycle; set wins over clear.
- Packets are not repaired after a drop. The downstream consumer must treat overflow as fatal for the current packet.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, occupancy=0, pause_req=0, overflow=0, pointers=0. Reset takes effect immediately (asynchronous), and rst deassertion is synchronised by the caller. Asserting rst mid-operation discards all contents.
- Latency: a beat written into an empty buffer at edge N has m_axis_tvalid=1 after edge N+1, i.e. one cycle.
- Throughput: one beat per cycle in and out concurrently at any occupancy, including full.
- occupancy, pause_req and overflow all update on the same edge as the triggering write or pop.
- Empty with a pop is impossible (tvalid=0). Empty with a write takes the bypass path. Full with a write and a pop: the write is accepted and occupancy is unchanged.

## Test plan
- Write 5 beats (tdata=1..5, last on 5) with m_axis_tready=0 → occupancy=5. Raise tready → beats 1..5 emitted on 5 consecutive cycles with tlast only on 5; occupancy returns to 0.
- Single beat into empty buffer at cycle 10 → m_axis_tvalid=1 in cycle 11 with matching tdata and tkeep.
- tready=0, write 64 beats then 1 more → 65th dropped, overflow=1, occupancy=64. Output order 1..64 intact. overflow_clr → overflow=0.
- Full buffer with s_axis_tvalid=1 and tready=1 for 20 cycles → no drop, occupancy stays 64, output sequence continuous.
- Hysteresis (DEFAULT params): fill to 47 → pause_req=0. Beat 48 → pause_req=1. Drain to 17 → still 1. At 16 → 0.
- Assert rst with occupancy=30 and pause_req=1 → all outputs 0 immediately. After release, a new beat appears with one-cycle latency and no stale data.
